// File: rtl/shift_serializer_if.sv
// Handshake and serial-egress bundle for shift_serializer.
interface shift_serializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             dir;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, data_in, dir,
    input  in_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  in_valid, data_in, dir,
    output in_ready, ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/shift_serializer.sv
// Parallel-to-serial egress: accepts a word over valid/ready and emits it
// MSB- or LSB-first, each bit held DIV cycles, then a done pulse and an
// optional GAP-cycle quiet period before the next word is accepted.
module shift_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  parameter int GAP   = 1
) (
  input logic            clk,
  input logic            rst,
  shift_serializer_if.slave bus
);
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg;
  logic             msb_first;
  logic [BCW-1:0]   bit_cnt;
  logic [DCW-1:0]   div_cnt;
  logic [GCW-1:0]   gap_cnt;
  logic             ser_out_q, ser_valid_q, busy_q, done_q;
  logic             ready, accept, bit_end, word_end, gap_end;

  assign accept   = bus.in_valid && ready;
  assign bit_end  = (div_cnt == DCW'(DIV - 1));
  assign word_end = bit_end && (bit_cnt == BCW'(WIDTH - 1));
  assign gap_end  = (gap_cnt == GCW'(GAP));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state: with GAP=0 the done cycle is already IDLE so words chain.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (accept)   state_d = S_SHIFT;
      S_SHIFT: if (word_end) state_d = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_end)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // in_ready is the only combinational output; masked during reset.
  always_comb begin
    ready = (state == S_IDLE) && !rst;
  end

  // Datapath and registered outputs; bit 0 is presented on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      msb_first   <= 1'b0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      gap_cnt     <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg       <= bus.data_in;
            msb_first   <= bus.dir;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            ser_out_q   <= bus.dir ? bus.data_in[WIDTH-1] : bus.data_in[0];
            ser_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (!bit_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else if (word_end) begin
            div_cnt     <= '0;
            gap_cnt     <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= (GAP > 0);
          end else begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (msb_first) begin
              shreg     <= {shreg[WIDTH-2:0], 1'b0};
              ser_out_q <= shreg[WIDTH-2];
            end else begin
              shreg     <= {1'b0, shreg[WIDTH-1:1]};
              ser_out_q <= shreg[1];
            end
          end
        end
        S_GAP: begin
          if (gap_end) busy_q  <= 1'b0;
          else         gap_cnt <= gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: two instances (DIV=1/GAP=1 and DIV=3/GAP=0),
// a timeline model derived from the accept cycle, and directed word tests.
module tb_shift_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v[2];
  logic       iv[2];
  logic [7:0] din[2];
  logic       dr[2];
  logic       o_sv[2], o_so[2], o_dn[2], o_bz[2], o_rd[2];

  shift_serializer_if #(.WIDTH(8)) ifa ();
  shift_serializer_if #(.WIDTH(8)) ifb ();

  assign ifa.in_valid = iv[0];
  assign ifa.data_in  = din[0];
  assign ifa.dir      = dr[0];
  assign ifb.in_valid = iv[1];
  assign ifb.data_in  = din[1];
  assign ifb.dir      = dr[1];
  assign o_sv[0] = ifa.ser_valid;
  assign o_so[0] = ifa.ser_out;
  assign o_dn[0] = ifa.done;
  assign o_bz[0] = ifa.busy;
  assign o_rd[0] = ifa.in_ready;
  assign o_sv[1] = ifb.ser_valid;
  assign o_so[1] = ifb.ser_out;
  assign o_dn[1] = ifb.done;
  assign o_bz[1] = ifb.busy;
  assign o_rd[1] = ifb.in_ready;

  shift_serializer #(.WIDTH(8), .DIV(1), .GAP(1)) u_a (.clk(clk), .rst(rst_v[0]), .bus(ifa));
  shift_serializer #(.WIDTH(8), .DIV(3), .GAP(0)) u_b (.clk(clk), .rst(rst_v[1]), .bus(ifb));

  function automatic int div_of(input int u); return (u == 0) ? 1 : 3; endfunction
  function automatic int gap_of(input int u); return (u == 0) ? 1 : 0; endfunction

  // Model state: cycle index, accept cycle of the current word, first ready cycle.
  int         cyc = 0;
  int         acc_k[2] = '{-1, -1};
  int         ready_at[2] = '{0, 0};
  logic [7:0] mword[2];
  logic       mdir[2];
  int         n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs during cycle cyc, from the word timeline.
  task automatic expv(input int u, output logic sv, output logic so, output logic dn,
                      output logic bz, output logic rd);
    int d, wd, i;
    wd = 8 * div_of(u);
    sv = 0; so = 0; dn = 0; bz = 0;
    rd = !rst_v[u] && (cyc >= ready_at[u]);
    if (acc_k[u] >= 0) begin
      d = cyc - acc_k[u];
      if (d >= 1 && d <= wd) begin
        i  = (d - 1) / div_of(u);
        sv = 1; bz = 1;
        so = mdir[u] ? mword[u][7-i] : mword[u][i];
      end
      if (d == wd + 1) dn = 1;
      if (gap_of(u) > 0 && d >= wd + 1 && d <= wd + 1 + gap_of(u)) bz = 1;
    end
  endtask

  // Model update at each rising edge.
  initial forever begin
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (rst_v[u]) begin
        acc_k[u]    = -1;
        ready_at[u] = cyc + 1;
      end else if (iv[u] && cyc >= ready_at[u]) begin
        acc_k[u]    = cyc;
        mword[u]    = din[u];
        mdir[u]     = dr[u];
        ready_at[u] = (gap_of(u) > 0) ? cyc + 8 * div_of(u) + 2 + gap_of(u)
                                      : cyc + 8 * div_of(u) + 1;
      end
    end
    cyc = cyc + 1;
  end

  // Compare every cycle at the falling edge.
  initial forever begin
    logic e_sv, e_so, e_dn, e_bz, e_rd;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      expv(u, e_sv, e_so, e_dn, e_bz, e_rd);
      chk($sformatf("u%0d ser_valid", u), o_sv[u], e_sv);
      chk($sformatf("u%0d ser_out", u),   o_so[u], e_so);
      chk($sformatf("u%0d done", u),      o_dn[u], e_dn);
      chk($sformatf("u%0d busy", u),      o_bz[u], e_bz);
      chk($sformatf("u%0d in_ready", u),  o_rd[u], e_rd);
    end
  end

  task automatic tick(); @(posedge clk); #2; endtask

  task automatic wait_ready(input int u);
    int w = 0;
    while (!(cyc >= ready_at[u] && !rst_v[u]) && w < 100) begin tick(); w++; end
    if (w >= 100) chk("wait ready timeout", 0, 1);
  endtask

  // Send one word and observe until in_ready returns.
  task automatic run_word(input int u, input logic [7:0] d, input logic dirb, input bit toggle,
                          output logic [31:0] seq, output int nb, output int done_off,
                          output int rdy_off, output int ndone);
    int k;
    seq = '0; nb = 0; done_off = -1; rdy_off = -1; ndone = 0;
    iv[u] = 1; din[u] = d; dr[u] = dirb;
    wait_ready(u);
    k = cyc;
    tick();
    iv[u] = 0;
    for (int c = 1; c <= 40; c++) begin
      if (toggle) begin din[u] = 8'($urandom); dr[u] = 1'($urandom); end
      #1;
      if (o_sv[u] && nb < 32) begin seq[nb] = o_so[u]; nb++; end
      if (o_dn[u]) begin done_off = cyc - k; ndone++; end
      if (o_rd[u]) begin rdy_off = cyc - k; break; end
      tick();
    end
  endtask

  initial begin
    logic [31:0] seq;
    int nb, doff, roff, nd, k, nsv;
    rst_v = '{1'b1, 1'b1}; iv = '{1'b1, 1'b1}; din = '{8'hC3, 8'h3C}; dr = '{1'b1, 1'b1};

    // Reset held with in_valid high.
    repeat (3) begin
      tick(); #1;
      chk("rst in_ready", o_rd[0], 0);
      chk("rst ser_valid", o_sv[0], 0);
      chk("rst busy", o_bz[0], 0);
      chk("rst done", o_dn[0], 0);
    end
    rst_v = '{1'b0, 1'b0}; iv = '{1'b0, 1'b0};
    #1 chk("post-rst in_ready", o_rd[0], 1);
    tick(); #1 chk("no accept in rst", o_bz[0], 0);

    // LSB-first 0x0A.
    run_word(0, 8'h0A, 1'b0, 1'b0, seq, nb, doff, roff, nd);
    chk("lsb seq", seq, 32'h0A);
    chk("lsb nbits", nb, 8);
    chk("lsb done off", doff, 9);
    chk("lsb ready off", roff, 11);

    // MSB-first 0x0A with inputs toggling mid-word.
    run_word(0, 8'h0A, 1'b1, 1'b1, seq, nb, doff, roff, nd);
    chk("msb seq", seq, 32'h50);
    chk("msb nbits", nb, 8);
    chk("msb ndone", nd, 1);

    // Backpressure: 0x55 offered while 0x33 is in flight.
    iv[0] = 1; din[0] = 8'h33; dr[0] = 0;
    wait_ready(0);
    k = cyc;
    tick();
    din[0] = 8'h55;
    seq = '0; nb = 0; nd = 0; roff = -1;
    for (int c = 1; c <= 28; c++) begin
      if (iv[0] && acc_k[0] != k) iv[0] = 0;
      #1;
      if (o_sv[0] && nb < 32) begin seq[nb] = o_so[0]; nb++; end
      if (o_dn[0]) nd++;
      if (o_rd[0] && roff < 0) roff = cyc - k;
      tick();
    end
    chk("bp seq", seq, 32'h5533);
    chk("bp nbits", nb, 16);
    chk("bp ndone", nd, 2);
    chk("bp ready off", roff, 11);

    // Reset after 4 bits of 0xF0.
    iv[0] = 1; din[0] = 8'hF0; dr[0] = 1;
    wait_ready(0);
    k = cyc;
    tick();
    iv[0] = 0;
    seq = '0; nb = 0;
    repeat (4) begin
      #1; if (o_sv[0]) begin seq[nb] = o_so[0]; nb++; end
      tick();
    end
    rst_v[0] = 1;
    tick();
    rst_v[0] = 0;
    #1;
    chk("midrst bits", seq, 32'hF);
    chk("midrst ser_valid", o_sv[0], 0);
    chk("midrst busy", o_bz[0], 0);
    nd = 0;
    repeat (12) begin #1; if (o_dn[0]) nd++; tick(); end
    chk("midrst no done", nd, 0);
    run_word(0, 8'h0A, 1'b0, 1'b0, seq, nb, doff, roff, nd);
    chk("after rst seq", seq, 32'h0A);
    chk("after rst done off", doff, 9);

    // DIV=3, GAP=0: 0x81 MSB-first then 0xFF back-to-back.
    iv[1] = 1; din[1] = 8'h81; dr[1] = 1;
    wait_ready(1);
    k = cyc;
    tick();
    din[1] = 8'hFF;
    seq = '0; nsv = 0;
    for (int c = 1; c <= 30; c++) begin
      #1;
      if (c <= 24 && o_sv[1]) begin seq[nsv] = o_so[1]; nsv++; end
      if (c == 25) begin
        chk("hold done", o_dn[1], 1);
        chk("hold ready w/ done", o_rd[1], 1);
        chk("hold sv at done", o_sv[1], 0);
      end
      if (c == 26) begin
        iv[1] = 0;
        chk("b2b sv", o_sv[1], 1);
        chk("b2b so", o_so[1], 1);
        chk("b2b busy", o_bz[1], 1);
      end
      tick();
    end
    chk("hold seq", seq, 32'hE00007);
    chk("hold nvalid", nsv, 24);

    repeat (30) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
